// File: rtl/pipelined_shifter_if.sv
// Handshake bundle for pipelined_shifter: an input operand channel and a result channel.
// The master drives operands and accepts results; the slave is the shifter itself.
interface pipelined_shifter_if #(
    parameter int WIDTH = 32
);
    localparam int SHAMT_W = $clog2(WIDTH);

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic [1:0]         in_mode;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;

    modport master (
        output in_valid,
        output in_data,
        output in_shamt,
        output in_mode,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_shamt,
        input  in_mode,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/pipelined_shifter.sv
// Barrel shifter split into log2(WIDTH) registered stages (SLL/SRL/SRA/ROL) with valid/ready flow control.
// Define PIPELINED_SHIFTER_ROTATE_EN to build ROL; otherwise mode 11 flows through and yields zero.
module pipelined_shifter #(
    parameter int WIDTH = 32
) (
    input logic                clock,
    input logic                reset,
    pipelined_shifter_if.slave bus
);
    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int LAST    = SHAMT_W - 1;

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROL = 2'b11;

    logic [WIDTH-1:0]   data_q  [SHAMT_W];
    logic [WIDTH-1:0]   data_d  [SHAMT_W];
    logic [1:0]         mode_q  [SHAMT_W];
    logic [1:0]         mode_d  [SHAMT_W];
    logic [SHAMT_W-1:0] shamt_q [SHAMT_W];
    logic [SHAMT_W-1:0] shamt_d [SHAMT_W];
    logic [SHAMT_W-1:0] valid_q;
    logic [SHAMT_W-1:0] valid_d;
    logic [SHAMT_W-1:0] sign_q;
    logic [SHAMT_W-1:0] sign_d;

    logic               stall;
    logic               accept;
    logic [WIDTH-1:0]   operand;

    function automatic logic [WIDTH-1:0] stage_shift(
        input logic [WIDTH-1:0] value,
        input logic [1:0]       mode,
        input logic             sign,
        input logic             enable,
        input int               k
    );
        int amt;
        logic [WIDTH-1:0] result;
        amt    = 1 << k;
        result = value;
        if (enable) begin
            case (mode)
                MODE_SLL: result = value << amt;
                MODE_SRL: result = value >> amt;
                MODE_SRA: result = (value >> amt) | ({WIDTH{sign}} & ~({WIDTH{1'b1}} >> amt));
`ifdef PIPELINED_SHIFTER_ROTATE_EN
                MODE_ROL: result = (value << amt) | (value >> (WIDTH - amt));
`endif
                default:  result = '0;
            endcase
        end
        return result;
    endfunction

    assign stall        = valid_q[LAST] && !bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign bus.in_ready = !stall && !reset;
    assign bus.out_valid = valid_q[LAST];
    assign bus.out_data  = data_q[LAST];

    // Without rotate support the operand is zeroed at entry, so mode 11 carries zero through every stage.
`ifdef PIPELINED_SHIFTER_ROTATE_EN
    assign operand = bus.in_data;
`else
    assign operand = (bus.in_mode == MODE_ROL) ? '0 : bus.in_data;
`endif

    always_comb begin
        valid_d = valid_q;
        sign_d  = sign_q;
        for (int k = 0; k < SHAMT_W; k++) begin
            data_d[k]  = data_q[k];
            mode_d[k]  = mode_q[k];
            shamt_d[k] = shamt_q[k];
        end
        if (!stall) begin
            valid_d[0] = accept;
            mode_d[0]  = bus.in_mode;
            shamt_d[0] = bus.in_shamt;
            sign_d[0]  = bus.in_data[WIDTH-1];
            data_d[0]  = stage_shift(operand, bus.in_mode, bus.in_data[WIDTH-1], bus.in_shamt[0], 0);
            for (int k = 1; k < SHAMT_W; k++) begin
                valid_d[k] = valid_q[k-1];
                mode_d[k]  = mode_q[k-1];
                shamt_d[k] = shamt_q[k-1];
                sign_d[k]  = sign_q[k-1];
                data_d[k]  = stage_shift(data_q[k-1], mode_q[k-1], sign_q[k-1], shamt_q[k-1][k], k);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            sign_q  <= '0;
            for (int k = 0; k < SHAMT_W; k++) begin
                data_q[k]  <= '0;
                mode_q[k]  <= '0;
                shamt_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            sign_q  <= sign_d;
            for (int k = 0; k < SHAMT_W; k++) begin
                data_q[k]  <= data_d[k];
                mode_q[k]  <= mode_d[k];
                shamt_q[k] <= shamt_d[k];
            end
        end
    end
endmodule

// File: tb/tb_pipelined_shifter.sv
// Directed bench for pipelined_shifter at WIDTH=32 with a scoreboard of expected results.
// Follows PIPELINED_SHIFTER_ROTATE_EN to pick the expected mode-11 result.
module tb_pipelined_shifter;
    logic clock = 1'b0;
    logic reset;

    pipelined_shifter_if #(.WIDTH(32)) bus ();

    pipelined_shifter #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    logic [31:0] sb [$];
    logic [31:0] exp_v;
    int vectors     = 0;
    int miscompares = 0;
    int pop_count   = 0;

    function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] s, input logic [1:0] m);
        logic [31:0] r;
        case (m)
            2'b00:   r = d << s;
            2'b01:   r = d >> s;
            2'b10:   r = $unsigned($signed(d) >>> s);
`ifdef PIPELINED_SHIFTER_ROTATE_EN
            default: r = (s == 5'd0) ? d : ((d << s) | (d >> (6'd32 - {1'b0, s})));
`else
            default: r = 32'h0;
`endif
        endcase
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] d, input logic [4:0] s, input logic [1:0] m);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_shamt = s;
        bus.in_mode  = m;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            step();
            n++;
        end
        checkOutput({tag, "_drained"}, 32'(sb.size()), 32'd0);
    endtask

    // Scoreboard: push on accept, pop and compare on consume, flush on reset.
    always @(negedge clock) begin
        if (reset) begin
            sb.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                pop_count++;
                checkOutput("result_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    exp_v = sb.pop_front();
                    checkOutput("result_data", bus.out_data, exp_v);
                end
            end
            if (bus.in_valid && bus.in_ready)
                sb.push_back(model(bus.in_data, bus.in_shamt, bus.in_mode));
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int valid_cnt;
        int pops_before;
        int stale;
        logic ready_ok;
        logic [31:0] held;

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_shamt  = '0;
        bus.in_mode   = '0;
        bus.out_ready = 1'b1;
        step();
        step();
        checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_out_data", bus.out_data, 32'd0);
        checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("post_reset_in_ready", 32'(bus.in_ready), 32'd1);

        // SLL by 31 and the five-edge latency
        applyStimulus(32'h0000_0001, 5'd31, 2'b00);
        step();
        bus.in_valid = 1'b0;
        n = 1;
        while (!bus.out_valid && n < 20) begin
            step();
            n++;
        end
        checkOutput("sll_latency", 32'(n), 32'd5);
        checkOutput("sll_data", bus.out_data, 32'h8000_0000);
        drain("sll");

        // Right shifts with sign fill, and zero shift amount
        applyStimulus(32'h8000_0000, 5'd4, 2'b10); step();
        applyStimulus(32'h8000_0000, 5'd4, 2'b01); step();
        applyStimulus(32'h8000_0000, 5'd0, 2'b10); step();
        applyStimulus(32'h8000_0000, 5'd0, 2'b01); step();
        applyStimulus(32'h1234_5678, 5'd0, 2'b00); step();
        bus.in_valid = 1'b0;
        drain("right");

        // Rotate left by one
        applyStimulus(32'h8000_0001, 5'd1, 2'b11); step();
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            step();
            n++;
        end
`ifdef PIPELINED_SHIFTER_ROTATE_EN
        checkOutput("rol_data", bus.out_data, 32'h0000_0003);
`else
        checkOutput("rol_data", bus.out_data, 32'h0000_0000);
`endif
        drain("rol");

        // Eight back-to-back transactions streaming with out_ready held high
        pops_before = pop_count;
        valid_cnt   = 0;
        ready_ok    = 1'b1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(32'h1234_5678 ^ (32'(i) * 32'h9E37_79B9), 5'(i * 3 + 1), 2'(i));
            if (!bus.in_ready) ready_ok = 1'b0;
            step();
            if (bus.out_valid) valid_cnt++;
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.out_valid) valid_cnt++;
        end
        checkOutput("stream_in_ready", 32'(ready_ok), 32'd1);
        checkOutput("stream_valid_cycles", 32'(valid_cnt), 32'd8);
        step();
        checkOutput("stream_idle_after", 32'(bus.out_valid), 32'd0);
        checkOutput("stream_pops", 32'(pop_count - pops_before), 32'd8);

        // Fill the pipeline with out_ready low, stall three cycles, then release
        bus.out_ready = 1'b0;
        pops_before   = pop_count;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(32'hC3A5_0F0F + 32'(i), 5'(i * 7 + 2), 2'(i + 1));
            step();
        end
        bus.in_valid = 1'b0;
        checkOutput("full_out_valid", 32'(bus.out_valid), 32'd1);
        held = bus.out_data;
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall_in_ready", 32'(bus.in_ready), 32'd0);
            checkOutput("stall_hold", bus.out_data, held);
            step();
        end
        bus.out_ready = 1'b1;
        drain("backpressure");
        checkOutput("backpressure_pops", 32'(pop_count - pops_before), 32'd5);

        // Reset with three transactions in flight
        for (int i = 0; i < 3; i++) begin
            applyStimulus(32'hDEAD_BEEF >> i, 5'd3, 2'b00);
            step();
        end
        bus.in_valid = 1'b0;
        reset = 1'b1;
        step();
        checkOutput("midreset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("midreset_out_data", bus.out_data, 32'd0);
        checkOutput("midreset_in_ready", 32'(bus.in_ready), 32'd0);
        reset = 1'b0;
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.out_valid) stale++;
        end
        checkOutput("midreset_no_stale", 32'(stale), 32'd0);

        checkOutput("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
